lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 218 +++++++++++++++++++++
 tb/tb_lsu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit sitting between the EX stage and a
// req/gnt + rvalid memory port.
//
// Ports
//   clk, reset                 sole clock; synchronous active-high reset
//   valid_i, memren_i,         EX-stage op valid, load request, store request
//   memwren_i
//   funct3_i, addr_i,          access size/sign, effective address, store data,
//   wdata_i, rd_i              load destination register
//   stall_o                    holds the upstream pipeline while an access is busy
//   mem_req_o .. mem_wdata_o   memory request (word-aligned address, byte enables)
//   mem_gnt_i, mem_rvalid_i,   memory grant and read response
//   mem_rdata_i
//   ld_valid_o, ld_data_o,     one-cycle load writeback (formatted data, rd)
//   ld_rd_o
//   misalign_o                 one-cycle misaligned-access flag
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses issue no
//                     memory request and pulse misalign_o instead. When undefined
//                     misalign_o is tied 0 and misaligned accesses are aligned
//                     down to their access size.
// -----------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        memren_i,
    input  logic        memwren_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic [4:0]  ld_rd_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;

    logic        accept;
    logic        is_byte, is_half;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic        stall, req, ld_valid;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_fmt;

`ifdef MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic misaligned, misalign;
`endif

    assign accept = valid_i && (memren_i || memwren_i);

    // funct3[1:0]: 00 byte, 01 half, anything else (2, 3, 6, 7) is a word.
    assign is_byte = (funct3_i[1:0] == 2'b00);
    assign is_half = (funct3_i[1:0] == 2'b01);

    // Lane placement: data is replicated so any byte lane can pick it up.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_i;
        if (is_byte) begin
            be_calc    = 4'b0001 << addr_i[1:0];
            wdata_calc = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_calc    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata_i[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (is_half && addr_i[0]) ||
                        (!is_byte && !is_half && (addr_i[1:0] != 2'b00));
`endif

    // Load formatting from the lane latched at acceptance.
    always_comb begin
        lane_b = mem_rdata_i[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        if (f3_q[1:0] == 2'b00) begin
            ld_fmt = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
        end else if (f3_q[1:0] == 2'b01) begin
            ld_fmt = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
        end else begin
            ld_fmt = mem_rdata_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        f3_d     = f3_q;
        off_d    = off_q;
        stall    = 1'b0;
        req      = 1'b0;
        ld_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap_d   = trap_q;
        misalign = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = StReq;
                    we_d    = memwren_i;  // store wins when both are set
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    rd_d    = rd_i;
                    f3_d    = funct3_i;
                    off_d   = addr_i[1:0];
`ifdef MISALIGN_TRAP_EN
                    trap_d  = misaligned;
`endif
                end
            end
            StReq: begin
`ifdef MISALIGN_TRAP_EN
                if (trap_q) begin
                    // Trapped access: flag it and drop back without touching memory.
                    misalign = 1'b1;
                    state_d  = StIdle;
                end else
`endif
                begin
                    req = 1'b1;
                    if (mem_gnt_i) begin
                        state_d = we_q ? StIdle : StWait;
                        stall   = !we_q;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    ld_valid = 1'b1;
                    state_d  = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign stall_o     = stall;
    assign mem_req_o   = req;
    assign mem_we_o    = req && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign ld_valid_o  = ld_valid;
    assign ld_data_o   = ld_valid ? ld_fmt : 32'd0;
    assign ld_rd_o     = rd_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o  = misalign;
`else
    assign misalign_o  = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- scoreboard bench for lsu. Stimulus pushes expected memory requests
// and load results into queues; a monitor pops and compares whenever the DUT
// presents a granted request, a load writeback or a misalign flag. Expected
// values come from a byte-array memory model; the bench's responder memory is a
// separate word array written only through the DUT's own store requests.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, memren_i, memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        ld_valid_o;
    logic [31:0] ld_data_o;
    logic [4:0]  ld_rd_o;
    logic        misalign_o;

    lsu dut (
        .clk          (clk),
        .reset        (reset),
        .valid_i      (valid_i),
        .memren_i     (memren_i),
        .memwren_i    (memwren_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_i         (rd_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .ld_valid_o   (ld_valid_o),
        .ld_data_o    (ld_data_o),
        .ld_rd_o      (ld_rd_o),
        .misalign_o   (misalign_o)
    );

    always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } ld_t;

    req_t req_q[$];
    ld_t  ld_q[$];
    int   mis_pending = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [7:0]  mm   [64];  // reference memory, byte granular
    logic [31:0] phys [16];  // responder memory, written by DUT stores

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 1'b0;
        if (f3[1:0] == 2'b01) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    // Scoreboard monitor, sampled well after the negedge where stimulus changes.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            if (mem_req_o && mem_gnt_i) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req_o), 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", mem_addr_o, r.addr);
                    chk("req_we", 32'(mem_we_o), 32'(r.we));
                    chk("req_be", 32'(mem_be_o), 32'(r.be));
                    if (r.we) chk("req_wdata", mem_wdata_o, r.wdata);
                end
            end
            if (ld_valid_o) begin
                if (ld_q.size() == 0) begin
                    chk("unexpected_ld_valid", 32'(ld_valid_o), 32'd0);
                end else begin
                    ld_t l;
                    l = ld_q.pop_front();
                    chk("ld_data", ld_data_o, l.data);
                    chk("ld_rd", 32'(ld_rd_o), 32'(l.rd));
                end
            end
            if (misalign_o) begin
                chk("misalign_expected", 32'(mis_pending > 0), 32'd1);
                if (mis_pending > 0) mis_pending--;
            end
        end
    end

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int gdly, input int rdly);
        req_t        r;
        ld_t         l;
        bit          mis;
        logic [5:0]  b, hb, wb;
        logic [15:0] h;
        logic [3:0]  gidx;

        mis    = Trap && is_mis(f3, a);
        b      = a[5:0];
        hb     = {b[5:1], 1'b0};
        wb     = {b[5:2], 2'b00};
        r.addr = {a[31:2], 2'b00};
        r.we   = st;
        if (f3[1:0] == 2'b00) begin
            r.be    = 4'b0001 << a[1:0];
            r.wdata = {4{wd[7:0]}};
        end else if (f3[1:0] == 2'b01) begin
            r.be    = a[1] ? 4'b1100 : 4'b0011;
            r.wdata = {2{wd[15:0]}};
        end else begin
            r.be    = 4'b1111;
            r.wdata = wd;
        end
        l.rd = rd;
        if (f3[1:0] == 2'b00) begin
            l.data = f3[2] ? 32'(mm[b]) : 32'($signed(mm[b]));
        end else if (f3[1:0] == 2'b01) begin
            h      = {mm[hb + 6'd1], mm[hb]};
            l.data = f3[2] ? 32'(h) : 32'($signed(h));
        end else begin
            l.data = {mm[wb + 6'd3], mm[wb + 6'd2], mm[wb + 6'd1], mm[wb]};
        end

        if (mis) begin
            mis_pending++;
        end else begin
            req_q.push_back(r);
            if (st) begin
                if (f3[1:0] == 2'b00) begin
                    mm[b] = wd[7:0];
                end else if (f3[1:0] == 2'b01) begin
                    mm[hb] = wd[7:0];
                    mm[hb + 6'd1] = wd[15:8];
                end else begin
                    for (int k = 0; k < 4; k++) mm[wb + 6'(k)] = wd[8*k +: 8];
                end
            end else begin
                ld_q.push_back(l);
            end
        end

        @(negedge clk);
        valid_i = 1'b1; memren_i = ld; memwren_i = st;
        funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
        #1 chk("stall_accept", 32'(stall_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom);
        if (mis) begin
            #1 chk("mis_no_req", 32'(mem_req_o), 32'd0);
            @(negedge clk);
            #1 chk("mis_idle_stall", 32'(stall_o), 32'd0);
            return;
        end
        for (int i = 0; i < gdly; i++) begin
            mem_rvalid_i = 1'($urandom);  // must be ignored outside WAIT
            #1;
            chk("req_held", 32'(mem_req_o), 32'd1);
            chk("stall_req", 32'(stall_o), 32'd1);
            chk("addr_stable", mem_addr_o, r.addr);
            chk("be_stable", 32'(mem_be_o), 32'(r.be));
            if (st) chk("wdata_stable", mem_wdata_o, r.wdata);
            chk("no_ld_in_req", 32'(ld_valid_o), 32'd0);
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        #1;
        gidx = mem_addr_o[5:2];
        if (st) begin
            for (int k = 0; k < 4; k++)
                if (mem_be_o[k]) phys[gidx][8*k +: 8] = mem_wdata_o[8*k +: 8];
            chk("stall_store_done", 32'(stall_o), 32'd0);
        end else begin
            chk("stall_load_gnt", 32'(stall_o), 32'd1);
        end
        @(negedge clk);
        mem_gnt_i = 1'b0;
        if (!st) begin
            for (int i = 0; i < rdly; i++) begin
                #1;
                chk("stall_wait", 32'(stall_o), 32'd1);
                chk("no_ld_early", 32'(ld_valid_o), 32'd0);
                @(negedge clk);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = phys[gidx];
            #1 chk("stall_ld_done", 32'(stall_o), 32'd0);
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_be"}, 32'(mem_be_o), 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_ld_valid"}, 32'(ld_valid_o), 32'd0);
        chk({tag, "_ld_rd"}, 32'(ld_rd_o), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign_o), 32'd0);
    endtask

    initial begin
        req_t rr;
        bit   ld, st;
        int   k;
        logic [2:0] f3;

        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
        for (int i = 0; i < 16; i++) phys[i] = 32'h0;
        reset = 1'b1; valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0; rd_i = 5'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_2000, 32'h0000_8000, 5'd0, 0, 0);
        run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd0, 0, 0);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 5'd5, 0, 0);
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 5'd6, 0, 0);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_2000, 32'h0, 5'd12, 3, 2);
        run_op(1'b1, 1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 5'd3, 1, 0);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_3001, 32'h0, 5'd7, 0, 1);
        run_op(1'b1, 1'b0, 3'd6, 32'h0000_1004, 32'h0, 5'd8, 0, 0);

        // Reset while a load waits for its data.
        rr.addr = 32'h0000_2000; rr.we = 1'b0; rr.be = 4'b1111; rr.wdata = 32'd0;
        req_q.push_back(rr);
        @(negedge clk);
        valid_i = 1'b1; memren_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h0000_2000; rd_i = 5'd9;
        @(negedge clk);
        valid_i = 1'b0; memren_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk_all_zero("post_reset");
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #1;
        chk("rst_no_ld_valid", 32'(ld_valid_o), 32'd0);
        chk("rst_no_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1 chk("rst_still_idle", 32'(ld_valid_o), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            k  = $urandom_range(0, 9);
            st = (k < 4) || (k == 9);
            ld = (k >= 4);
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            run_op(ld, st, f3, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("ld_q_drained", 32'(ld_q.size()), 32'd0);
        chk("mis_drained", 32'(mis_pending), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
